if_id_fifo: RTL and testbench

- Decoupling buffer between the instruction memory read port and the decode stage.
- Captures each fetched {pc, instruction} pair and presents it to decode with a valid/ready handshake.
- Absorbs decode stalls without dropping fetched words.
- Discards all buffered words on a pipeline flush (branch/jump redirect), so decode never sees wrong-path instructions.

---
 rtl/if_id_fifo.sv | 62 ++++++
 tb/tb_if_id_fifo.sv | 129 ++++++++++++
 2 files changed

// File: rtl/if_id_fifo.sv
// IF/ID decoupling buffer: holds fetched {pc, inst} pairs until decode takes them.
// A flush drops everything held, plus the word arriving that cycle.
module if_id_fifo #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            valid_o,
  input  logic            ready_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][XLEN-1:0] mem_pc;
  logic [DEPTH-1:0][XLEN-1:0] mem_inst;
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [CW-1:0]              count;
  logic                       push;
  logic                       pop;

  // Handshake outputs come only from count, so there is no ready_i -> ready_o path.
  assign ready_o = (count != CW'(DEPTH));
  assign valid_o = (count != '0);
  assign push    = valid_i & ready_o & ~flush_i;
  assign pop     = valid_o & ready_i & ~flush_i;

  assign pc_o    = valid_o ? mem_pc[rd_ptr]   : '0;
  assign inst_o  = valid_o ? mem_inst[rd_ptr] : NOP_INST;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: an entry is only read once count says it is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_pc[wr_ptr]   <= pc_i;
      mem_inst[wr_ptr] <= inst_i;
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// Scoreboard bench for if_id_fifo: accepted words go into a queue, and the DUT head
// is compared against the queue front every cycle.
module tb_if_id_fifo;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] pc_in, inst_in, pc_out, inst_out;
  logic            vld_in, rdy_out, flush, vld_out, rdy_in;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ent_t;
  ent_t sb[$];

  if_id_fifo #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pc_i(pc_in), .inst_i(inst_in), .valid_i(vld_in),
    .ready_o(rdy_out), .flush_i(flush), .pc_o(pc_out), .inst_o(inst_out),
    .valid_o(vld_out), .ready_i(rdy_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, predict the accepted push and pop, clock, then compare the DUT with the model.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [XLEN-1:0] p, input logic [XLEN-1:0] i, input logic rd);
    bit do_push, do_pop;
    rst_n = r; flush = f; vld_in = v; pc_in = p; inst_in = i; rdy_in = rd;
    do_push = v && (sb.size() != DEPTH) && !f;
    do_pop  = (sb.size() != 0) && rd && !f;
    @(posedge clk);
    if (!r || f) sb.delete();
    else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back('{pc: p, inst: i});
    end
    #1;
    chk("valid_o", XLEN'(vld_out), XLEN'(sb.size() != 0));
    chk("ready_o", XLEN'(rdy_out), XLEN'(sb.size() != DEPTH));
    chk("pc_o",   pc_out,   (sb.size() != 0) ? sb[0].pc   : '0);
    chk("inst_o", inst_out, (sb.size() != 0) ? sb[0].inst : NOP);
  endtask

  task automatic idle(input logic rd);
    step(1'b1, 1'b0, 1'b0, '0, '0, rd);
  endtask

  initial begin
    logic [XLEN-1:0] p;
    // reset
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("rst_valid", XLEN'(vld_out), '0);
    chk("rst_ready", XLEN'(rdy_out), 32'd1);
    chk("rst_pc",    pc_out,   '0);
    chk("rst_inst",  inst_out, NOP);

    // single word: it is visible in the cycle after it is pushed, then popped
    step(1'b1, 1'b0, 1'b1, 32'h80000000, 32'h00500093, 1'b0);
    chk("single_pc",   pc_out,   32'h80000000);
    chk("single_inst", inst_out, 32'h00500093);
    idle(1'b1);
    chk("single_drained", inst_out, NOP);

    // fill while decode is stalled; the third word is refused
    step(1'b1, 1'b0, 1'b1, 32'h80000000, 32'h00000001, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h80000004, 32'h00000002, 1'b0);
    chk("full_ready", XLEN'(rdy_out), '0);
    step(1'b1, 1'b0, 1'b1, 32'h80000008, 32'h00000003, 1'b0);
    chk("full_head", pc_out, 32'h80000000);
    idle(1'b1);
    chk("drain1", pc_out, 32'h80000004);
    idle(1'b1);
    idle(1'b1);

    // streaming across pointer wrap
    for (int k = 0; k < 10; k++)
      step(1'b1, 1'b0, 1'b1, 32'h80000000 + 32'(4 * k), 32'h00100013 + 32'(k << 7), 1'b1);
    chk("stream_last", pc_out, 32'h80000024);
    idle(1'b1);

    // push and pop together at count=1
    step(1'b1, 1'b0, 1'b1, 32'h80000000, 32'h11111111, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h80000004, 32'h22222222, 1'b1);
    chk("pushpop_pc", pc_out, 32'h80000004);
    idle(1'b1);

    // flush mid-stream: the word arriving with the flush is dropped
    step(1'b1, 1'b0, 1'b1, 32'h80000000, 32'h0000aaaa, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h80000004, 32'h0000bbbb, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h80000008, 32'h0000cccc, 1'b1);
    chk("flush_valid", XLEN'(vld_out), '0);
    chk("flush_ready", XLEN'(rdy_out), 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h80000100, 32'h0000dddd, 1'b0);
    chk("after_flush_pc", pc_out, 32'h80000100);

    // reset takes priority over flush, push and pop
    step(1'b1, 1'b0, 1'b1, 32'h80000104, 32'h0000eeee, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h80000108, 32'h0000ffff, 1'b1);
    chk("rstpri_valid", XLEN'(vld_out), '0);
    chk("rstpri_pc",    pc_out,   '0);
    chk("rstpri_inst",  inst_out, NOP);
    chk("rstpri_ready", XLEN'(rdy_out), 32'd1);

    // random traffic, with an occasional flush
    p = 32'h90000000;
    for (int k = 0; k < 300; k++) begin
      step(1'b1, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), p, $urandom, 1'($urandom_range(0, 1)));
      p = p + 32'd4;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
